// File: rtl/regfile_multiport.sv
// Three-read, one-write register file with registered read data, write-through bypass,
// and a sequential clear engine that wipes one register per cycle while busy is high.
module regfile_multiport #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] rd_addr3,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_data3,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    output logic              busy,
    output logic              wr_dropped
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   index, index_next;
    logic                busy_next;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                wr_blocked;
    logic                wr_ok;

    // Address 0 is hard-wired when ZERO_REG is set: writes there are silently ignored.
    assign wr_blocked = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok      = wr_en && !busy && !wr_blocked;

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        if (wr_ok && (wr_addr == addr))
            return wr_data;
        return regs[addr];
    endfunction

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        index_next = index;
        busy_next  = busy;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    index_next = '0;
                    busy_next  = 1'b1;
                end
            end
            CLEAR: begin
                if (index == LAST_IDX) begin
                    state_next = IDLE;
                    index_next = '0;
                    busy_next  = 1'b0;
                end else begin
                    index_next = index + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            index <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            index <= index_next;
            busy  <= busy_next;
        end
    end

    // NOTE: the array is reset in one cycle on purpose; this forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_data;
            if (state == CLEAR)
                regs[index] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data1   <= '0;
            rd_data2   <= '0;
            rd_data3   <= '0;
            wr_dropped <= 1'b0;
        end else begin
            rd_data1 <= read_port(rd_addr1);
            rd_data2 <= read_port(rd_addr2);
            rd_data3 <= read_port(rd_addr3);
            if (wr_en && busy && !wr_blocked)
                wr_dropped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: one instance with ZERO_REG=0 and one with ZERO_REG=1 share stimulus
// and are compared every cycle against an array-based reference model, plus directed scenario checks.
module tb_regfile_multiport;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ra [3];
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       clear_req;

    logic [7:0] rd_a [3];
    logic [7:0] rd_z [3];
    logic       busy_a, busy_z, drop_a, drop_z;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: [0] = plain file, [1] = zero-register file
    logic [7:0] m_mem  [2][8];
    logic [7:0] m_rd   [2][3];
    logic       m_drop [2];
    logic       m_busy;
    int         m_pos;

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(ra[0]), .rd_addr2(ra[1]), .rd_addr3(ra[2]),
        .rd_data1(rd_a[0]), .rd_data2(rd_a[1]), .rd_data3(rd_a[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .busy(busy_a), .wr_dropped(drop_a)
    );

    regfile_multiport #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_addr1(ra[0]), .rd_addr2(ra[1]), .rd_addr3(ra[2]),
        .rd_data1(rd_z[0]), .rd_data2(rd_z[1]), .rd_data3(rd_z[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .busy(busy_z), .wr_dropped(drop_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic blocked, acc;
        for (int v = 0; v < 2; v++) begin
            if (!rst) begin
                for (int i = 0; i < 8; i++) m_mem[v][i] = 8'h00;
                for (int n = 0; n < 3; n++) m_rd[v][n] = 8'h00;
                m_drop[v] = 1'b0;
            end else begin
                blocked = (v == 1) && (wr_addr == 3'd0);
                acc     = wr_en && !m_busy && !blocked;
                for (int n = 0; n < 3; n++) begin
                    if (v == 1 && ra[n] == 3'd0)      m_rd[v][n] = 8'h00;
                    else if (acc && wr_addr == ra[n]) m_rd[v][n] = wr_data;
                    else                              m_rd[v][n] = m_mem[v][ra[n]];
                end
                if (wr_en && m_busy && !blocked) m_drop[v] = 1'b1;
                if (acc) m_mem[v][wr_addr] = wr_data;
            end
        end
        if (!rst) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else if (m_busy) begin
            m_mem[0][m_pos] = 8'h00;
            m_mem[1][m_pos] = 8'h00;
            m_pos++;
            if (m_pos == 8) m_busy = 1'b0;
        end else if (clear_req) begin
            m_busy = 1'b1;
            m_pos  = 0;
        end
    endtask

    task automatic compare_all();
        for (int n = 0; n < 3; n++) begin
            check($sformatf("a.rd%0d", n + 1), rd_a[n], m_rd[0][n]);
            check($sformatf("z.rd%0d", n + 1), rd_z[n], m_rd[1][n]);
        end
        check("a.busy", busy_a, m_busy);
        check("z.busy", busy_z, m_busy);
        check("a.dropped", drop_a, m_drop[0]);
        check("z.dropped", drop_z, m_drop[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        clear_req = 1'b0;
        rst       = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 8'(8'h11 * (i + 1));
            cycle();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            ra[0] = 3'(i);
            cycle();
            check($sformatf("%s.r%0d", tag, i), rd_a[0], 8'h00);
        end
    endtask

    initial begin
        int n;
        ra[0] = 3'd0; ra[1] = 3'd0; ra[2] = 3'd0;
        wr_addr = 3'd0; wr_data = 8'h00;
        idle_inputs();
        m_busy = 1'b0; m_pos = 0;

        // reset state
        do_reset();
        check("reset.busy", busy_a, 1'b0);
        check("reset.rd1", rd_a[0], 8'h00);

        // write then read on all ports
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        cycle();
        wr_en = 1'b0; ra[0] = 3'd3; ra[1] = 3'd3; ra[2] = 3'd3;
        cycle();
        check("rd3.p1", rd_a[0], 8'hA5);
        check("rd3.p2", rd_a[1], 8'hA5);
        check("rd3.p3", rd_a[2], 8'hA5);

        // same-cycle bypass
        ra[0] = 3'd4; ra[1] = 3'd5;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        cycle();
        wr_en = 1'b0;
        check("bypass.p2", rd_a[1], 8'h3C);
        check("bypass.p1", rd_a[0], 8'h00);

        // full clear: busy must last exactly 8 cycles
        fill();
        ra[0] = 3'd2; ra[1] = 3'd6; ra[2] = 3'd7;
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        n = 0;
        for (int g = 0; g < 20 && busy_a; g++) begin
            n++;
            cycle();
        end
        check("clear.len", n, 8);
        read_all_zero("clear");

        // writes during clear are dropped; a second clear_req does not extend it
        fill();
        ra[0] = 3'd1;
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        n = 0;
        for (int g = 0; g < 20 && busy_a; g++) begin
            n++;
            wr_en     = (n == 3);
            wr_addr   = 3'd1;
            wr_data   = 8'hFF;
            clear_req = (n == 4);
            cycle();
        end
        wr_en = 1'b0; clear_req = 1'b0;
        check("drop.len", n, 8);
        check("drop.flag", drop_a, 1'b1);
        ra[0] = 3'd1;
        cycle();
        check("drop.r1", rd_a[0], 8'h00);
        cycle();
        check("drop.sticky", drop_a, 1'b1);

        // zero register: write to r0 ignored without a drop
        do_reset();
        ra[0] = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
        cycle();
        wr_en = 1'b0;
        check("zero.bypass", rd_z[0], 8'h00);
        check("zero.plain_bypass", rd_a[0], 8'h55);
        check("zero.dropped", drop_z, 1'b0);
        cycle();
        check("zero.r0", rd_z[0], 8'h00);

        // reset aborts a clear and wipes the array
        fill();
        ra[0] = 3'd7; ra[1] = 3'd6; ra[2] = 3'd5;
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("abort.busy", busy_a, 1'b0);
        check("abort.rd1", rd_a[0], 8'h00);
        check("abort.rd2", rd_a[1], 8'h00);
        check("abort.rd3", rd_a[2], 8'h00);
        read_all_zero("abort");
        check("abort.no_resume", busy_a, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) >= 2);
            wr_en     = $urandom_range(0, 1) == 1;
            clear_req = ($urandom_range(0, 99) < 5);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 8'($urandom);
            ra[0]     = 3'($urandom_range(0, 7));
            ra[1]     = 3'($urandom_range(0, 7));
            ra[2]     = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
